// File: rtl/maze_bintree_carver.sv
// Binary-tree maze carver: fills a GRID_W x GRID_H wall bitmap and carves one cell per clock.
// Optional feature: define MAZE_ENTRY_EXIT_EN to open an entry and an exit pixel when the maze completes.
`timescale 1ns/1ps
module maze_bintree_carver #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 64,
  parameter int DIM_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                seed,
  input  logic [DIM_W-1:0]           x_dimension,
  input  logic [DIM_W-1:0]           y_dimension,
  output logic [GRID_W*GRID_H-1:0]   maze_data,
  output logic                       busy,
  output logic                       finish
);

  localparam int MAX_CX = (GRID_W - 1) / 2;
  localparam int MAX_CY = (GRID_H - 1) / 2;
  localparam int CW     = $clog2(MAX_CX + 1);
  localparam int RW     = $clog2(MAX_CY + 1);
  localparam int NPIX   = GRID_W * GRID_H;
  localparam int IW     = $clog2(NPIX);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_CARVE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NPIX-1:0] maze_q, maze_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]   cx_q, cx_d, cx_max_q, cx_max_d;
  logic [RW-1:0]   cy_q, cy_d, cy_max_q, cy_max_d;

  logic [DIM_W:0]  x_plus1, y_plus1;
  logic [CW-1:0]   cx_lim;
  logic [RW-1:0]   cy_lim;
  logic [IW-1:0]   cell_idx, north_idx, east_idx;
  logic            last_col;
  int              px, py;

  // Handshake: start is accepted only in IDLE or DONE; busy is high in FILL/CARVE,
  // finish is high in DONE, and maze_data is meaningful only while finish is high.
  assign busy      = (state_q == S_FILL) || (state_q == S_CARVE);
  assign finish    = (state_q == S_DONE);
  assign maze_data = maze_q;

  always_comb begin
    x_plus1 = {1'b0, x_dimension} + (DIM_W+1)'(1);
    y_plus1 = {1'b0, y_dimension} + (DIM_W+1)'(1);
    cx_lim  = (int'(x_plus1) > MAX_CX) ? CW'(MAX_CX) : CW'(x_plus1);
    cy_lim  = (int'(y_plus1) > MAX_CY) ? RW'(MAX_CY) : RW'(y_plus1);
    px        = 2 * int'(cx_q) + 1;
    py        = 2 * int'(cy_q) + 1;
    cell_idx  = IW'(px + GRID_W * py);
    north_idx = IW'(px + GRID_W * (py - 1));
    east_idx  = IW'(px + 1 + GRID_W * py);
    last_col  = (cx_q == cx_max_q - CW'(1));
  end

  always_comb begin
    state_d  = state_q;
    maze_d   = maze_q;
    lfsr_d   = lfsr_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cx_max_d = cx_max_q;
    cy_max_d = cy_max_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cx_max_d = cx_lim;
          cy_max_d = cy_lim;
          lfsr_d   = (seed == 16'h0000) ? LFSR_INIT : seed;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        maze_d  = '1;
        cx_d    = '0;
        cy_d    = '0;
        state_d = S_CARVE;
      end
      S_CARVE: begin
        // cy reaching cy_max marks the wrap-up cycle after the last cell.
        if (cy_q == cy_max_q) begin
          state_d = S_DONE;
`ifdef MAZE_ENTRY_EXIT_EN
          maze_d[IW'(GRID_W)] = 1'b0;
          maze_d[IW'(2 * int'(cx_max_q) + GRID_W * (2 * int'(cy_max_q) - 1))] = 1'b0;
`endif
        end else begin
          maze_d[cell_idx] = 1'b0;
          if (cy_q == '0) begin
            if (!last_col) maze_d[east_idx] = 1'b0;
          end else if (last_col) begin
            maze_d[north_idx] = 1'b0;
          end else if (lfsr_q[0]) begin
            maze_d[north_idx] = 1'b0;
          end else begin
            maze_d[east_idx] = 1'b0;
          end
          lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
          if (last_col) begin
            cx_d = '0;
            cy_d = cy_q + RW'(1);
          end else begin
            cx_d = cx_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      maze_q   <= '1;
      lfsr_q   <= LFSR_INIT;
      cx_q     <= '0;
      cy_q     <= '0;
      cx_max_q <= CW'(1);
      cy_max_q <= RW'(1);
    end else begin
      state_q  <= state_d;
      maze_q   <= maze_d;
      lfsr_q   <= lfsr_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      cx_max_q <= cx_max_d;
      cy_max_q <= cy_max_d;
    end
  end

endmodule

// File: tb/tb_maze_bintree_carver.sv
// Scoreboard bench for maze_bintree_carver: directed runs push expected bitmaps and latencies,
// a monitor pops and compares on every rising edge of finish.
`timescale 1ns/1ps
module tb_maze_bintree_carver;
  localparam int GW = 64;
  localparam int GH = 64;
  localparam int DW = 5;
  localparam int NP = GW * GH;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   seed;
  logic [DW-1:0] xd, yd;
  logic [NP-1:0] maze_data;
  logic          busy, finish;

  maze_bintree_carver #(.GRID_W(GW), .GRID_H(GH), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .x_dimension(xd), .y_dimension(yd),
    .maze_data(maze_data), .busy(busy), .finish(finish)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [NP-1:0] exp_q[$];
  int            lat_q[$];
  int            t0_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [NP-1:0] last_map = '1;
  logic          fin_prev = 1'b0;
  logic [NP-1:0] mon_em;
  int            mon_lat, mon_t0;

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_map(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    int ndiff, first;
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      ndiff = 0;
      first = -1;
      for (int i = 0; i < NP; i++)
        if (act[i] !== exp[i]) begin
          ndiff++;
          if (first < 0) first = i;
        end
      $display("FAIL %s: %0d bits differ, first bit %0d got %b expected %b",
               name, ndiff, first, act[first], exp[first]);
    end
  endtask

  function automatic int clampd(input int d, input int grid);
    return (d + 1 > (grid - 1) / 2) ? (grid - 1) / 2 : d + 1;
  endfunction

  function automatic logic [NP-1:0] ee(input logic [NP-1:0] m, input int cxn, input int cyn);
    logic [NP-1:0] r;
    r = m;
`ifdef MAZE_ENTRY_EXIT_EN
    r[GW] = 1'b0;
    r[2 * cxn + GW * (2 * cyn - 1)] = 1'b0;
`endif
    return r;
  endfunction

  // Reference binary-tree maze written straight from the algorithm description.
  function automatic logic [NP-1:0] model(input int xdim, input int ydim, input logic [15:0] s);
    logic [NP-1:0] m;
    logic [15:0]   l;
    int cxn, cyn, px, py;
    cxn = clampd(xdim, GW);
    cyn = clampd(ydim, GH);
    l = (s == 16'h0) ? 16'hACE1 : s;
    m = '1;
    for (int cy = 0; cy < cyn; cy++)
      for (int cx = 0; cx < cxn; cx++) begin
        px = 2 * cx + 1;
        py = 2 * cy + 1;
        m[px + GW * py] = 1'b0;
        if (cy == 0) begin
          if (cx != cxn - 1) m[px + 1 + GW * py] = 1'b0;
        end else if (cx == cxn - 1 || l[0]) begin
          m[px + GW * (py - 1)] = 1'b0;
        end else begin
          m[px + 1 + GW * py] = 1'b0;
        end
        l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
      end
    return ee(m, cxn, cyn);
  endfunction

  function automatic int zeros_in(input logic [NP-1:0] m);
    int z;
    z = 0;
    for (int i = 0; i < NP; i++) if (!m[i]) z++;
    return z;
  endfunction

  // monitor: compare on each rising edge of finish
  always @(posedge clk) begin
    #1;
    if (finish && !fin_prev) begin
      last_map = maze_data;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_finish: got finish at cycle %0d expected none", cyc);
      end else begin
        mon_em  = exp_q.pop_front();
        mon_lat = lat_q.pop_front();
        mon_t0  = t0_q.pop_front();
        check_map("bitmap", maze_data, mon_em);
        check_int("latency", cyc - mon_t0, mon_lat);
        check_int("busy_at_finish", int'(busy), 0);
      end
    end
    fin_prev = finish;
  end

  // driver tasks
  task automatic run(input int xdim, input int ydim, input logic [15:0] s, input logic [NP-1:0] em);
    @(negedge clk);
    xd    = DW'(xdim);
    yd    = DW'(ydim);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(em);
    lat_q.push_back(clampd(xdim, GW) * clampd(ydim, GH) + 2);
    t0_q.push_back(cyc);
    check_int("busy_after_start", int'(busy), 1);
    check_int("finish_after_start", int'(finish), 0);
    @(negedge clk);
    start = 1'b0;
    xd    = DW'($urandom_range(0, 31));
    yd    = DW'($urandom_range(0, 31));
    seed  = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
      lat_q.delete();
      t0_q.delete();
    end
  endtask

  logic [NP-1:0] hm;
  int            t0a, zr, zc;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    seed  = 16'h0;
    xd    = '0;
    yd    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_map("reset_map", maze_data, '1);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_finish", int'(finish), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1x1: only the single cell pixel opens
    hm = '1; hm[65] = 1'b0;
    run(0, 0, 16'hACE1, ee(hm, 1, 1));
    wait_idle(20);

    // 2x1: cell, east wall, cell
    hm = '1; hm[65] = 1'b0; hm[66] = 1'b0; hm[67] = 1'b0;
    run(1, 0, 16'hACE1, ee(hm, 2, 1));
    wait_idle(20);

    // 1x2: cell, north wall of lower cell, cell
    hm = '1; hm[65] = 1'b0; hm[129] = 1'b0; hm[193] = 1'b0;
    run(0, 1, 16'h1111, ee(hm, 1, 2));
    wait_idle(20);

    // 2x2 seed ACE1: lfsr bit0 for cell (0,1) is 0 -> east wall (2,3) opens
    hm = '1;
    hm[65] = 1'b0; hm[66] = 1'b0; hm[67] = 1'b0; hm[131] = 1'b0;
    hm[193] = 1'b0; hm[194] = 1'b0; hm[195] = 1'b0;
    run(1, 1, 16'hACE1, ee(hm, 2, 2));
    wait_idle(30);

    // full clamped area, run twice with the same seed
    for (int r = 0; r < 2; r++) begin
      run(31, 31, 16'h1234, model(31, 31, 16'h1234));
      wait_idle(1100);
`ifdef MAZE_ENTRY_EXIT_EN
      check_int("full_zero_count", zeros_in(last_map), 1923);
`else
      check_int("full_zero_count", zeros_in(last_map), 1921);
`endif
      zr = 0;
      zc = 0;
      for (int i = 0; i < GW; i++) if (!last_map[i + GW * 63]) zr++;
      for (int i = 0; i < GH; i++) if (!last_map[63 + GW * i]) zc++;
      check_int("row63_zeros", zr, 0);
      check_int("col63_zeros", zc, 0);
    end

    // seed 0 behaves as ACE1
    run(5, 3, 16'h0000, model(5, 3, 16'hACE1));
    wait_idle(60);

    // start pulse during CARVE must not disturb the run
    run(3, 3, 16'h00FF, model(3, 3, 16'h00FF));
    repeat (4) @(negedge clk);
    start = 1'b1;
    xd    = DW'(2);
    seed  = 16'h0005;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // start held high: two back-to-back 1x1 runs
    @(negedge clk);
    xd = '0; yd = '0; seed = 16'hACE1; start = 1'b1;
    @(posedge clk);
    #1;
    t0a = cyc;
    hm = '1; hm[65] = 1'b0;
    exp_q.push_back(ee(hm, 1, 1)); lat_q.push_back(3); t0_q.push_back(t0a);
    exp_q.push_back(ee(hm, 1, 1)); lat_q.push_back(3); t0_q.push_back(t0a + 4);
    wait_idle(20);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("done_hold_finish", int'(finish), 1);
    check_map("done_hold_map", maze_data, ee(hm, 1, 1));

    // asynchronous reset during CARVE
    @(negedge clk);
    xd = DW'(7); yd = DW'(7); seed = 16'h3C3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_int("async_reset_busy", int'(busy), 0);
    check_int("async_reset_finish", int'(finish), 0);
    check_map("async_reset_map", maze_data, '1);
    @(negedge clk);
    reset = 1'b0;

    // recovery after reset
    run(2, 1, 16'hBEEF, model(2, 1, 16'hBEEF));
    wait_idle(30);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
